// File: rtl/demux_lane_pkg.sv
// Shared sizes and lane state encoding for the 1-to-32 lane distributor.
package demux_lane_pkg;

    localparam int SEL_W      = 5;
    localparam int DATA_W     = 2;
    localparam int NUM_LANES  = 2 ** SEL_W;
    localparam int DROP_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux_lane_slot.sv
// One-entry output buffer for a single lane.
//
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | no symbol held, valid low
//   FULL  | symbol held in data_q, valid high until popped
//
// A push in the same cycle as a pop keeps the slot FULL with new data,
// so a lane with a ready consumer sustains one symbol per cycle.
// data_out is not cleared on pop; it simply holds the last symbol.
module demux_lane_slot
    import demux_lane_pkg::*;
#(
    parameter int DW = demux_lane_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] data_in,
    output logic          valid,
    output logic [DW-1:0] data_out
);

    lane_state_t   state_q, state_d;
    logic [DW-1:0] data_q, data_d;

    // State and data registers, emptied asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next state: push wins over pop so pop+push stays FULL.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = FULL;
                    data_d  = data_in;
                end
            end
            FULL: begin
                if (push) begin
                    data_d = data_in;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign valid    = (state_q == FULL);
    assign data_out = data_q;

endmodule

// File: rtl/demux_lane_router.sv
// 1-to-NUM_LANES distributor: routes each accepted symbol to the lane picked
// by in_sel. Symbols aimed at unpopulated lanes are dropped and counted
// rather than stalling the input stream.
module demux_lane_router
    import demux_lane_pkg::*;
#(
    parameter int SEL_W     = demux_lane_pkg::SEL_W,
    parameter int DATA_W    = demux_lane_pkg::DATA_W,
    parameter int NUM_LANES = demux_lane_pkg::NUM_LANES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [NUM_LANES-1:0]        lane_en,
    output logic [NUM_LANES-1:0]        out_valid,
    output logic [NUM_LANES*DATA_W-1:0] out_data,
    input  logic [NUM_LANES-1:0]        out_ready,
    output logic [DROP_CNT_W-1:0]       drop_cnt,
    output logic                        err,
    output logic [SEL_W-1:0]            err_sel,
    input  logic                        err_clr
);

    logic                  accept;
    logic                  drop;
    logic [NUM_LANES-1:0]  push_vec;
    logic [NUM_LANES-1:0]  pop_vec;

    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  err_q, err_d;
    logic [SEL_W-1:0]      err_sel_q, err_sel_d;

    // Only the selected lane can stall the input; a disabled lane never does
    // because its traffic is discarded.
    assign in_ready = !lane_en[in_sel] || !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;
    assign drop     = accept && !lane_en[in_sel];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign push_vec[i] = accept && (in_sel == SEL_W'(i)) && lane_en[i];
        assign pop_vec[i]  = out_valid[i] && out_ready[i];

        demux_lane_slot #(
            .DW (DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_vec[i]),
            .pop      (pop_vec[i]),
            .data_in  (in_data),
            .valid    (out_valid[i]),
            .data_out (out_data[DATA_W*i +: DATA_W])
        );
    end

    // Drop bookkeeping: clear beats a same-cycle drop, counter saturates.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q;
        err_sel_d  = err_sel_q;
        if (err_clr) begin
            drop_cnt_d = '0;
            err_d      = 1'b0;
            err_sel_d  = '0;
        end else if (drop) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
            err_d     = 1'b1;
            err_sel_d = in_sel;
        end
    end

    // Drop status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
            err_sel_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
            err_sel_q  <= err_sel_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err      = err_q;
    assign err_sel  = err_sel_q;

endmodule

// File: tb/tb_demux_lane_router.sv
// Bench for demux_lane_router: a lane-array model tracks every held symbol
// and the drop status; each cycle all outputs are compared against it,
// with a few literal spot checks that pin the model to known answers.
module tb_demux_lane_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [1:0]  in_data;
    logic [31:0] lane_en;
    logic [31:0] out_valid;
    logic [63:0] out_data;
    logic [31:0] out_ready;
    logic [7:0]  drop_cnt;
    logic        err;
    logic [4:0]  err_sel;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit         m_v   [32];
    logic [1:0] m_d   [32];
    int         m_cnt;
    bit         m_err;
    logic [4:0] m_sel;

    demux_lane_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .lane_en   (lane_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .err       (err),
        .err_sel   (err_sel),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 2'b00;
        end
        m_cnt = 0;
        m_err = 1'b0;
        m_sel = '0;
    endfunction

    function automatic bit model_ready();
        return !lane_en[in_sel] || !m_v[in_sel] || out_ready[in_sel];
    endfunction

    task automatic compare_all();
        logic [31:0] ev;
        logic [63:0] ed;
        for (int i = 0; i < 32; i++) begin
            ev[i]        = m_v[i];
            ed[2*i +: 2] = m_d[i];
        end
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("drop_cnt", drop_cnt, m_cnt);
        chk("err", err, m_err);
        chk("err_sel", err_sel, m_sel);
        chk("in_ready", in_ready, model_ready());
    endtask

    // One clock: drive inputs, compare before the edge, advance the model.
    task automatic cycle(input logic v, input logic [4:0] s, input logic [1:0] d,
                         input logic [31:0] en, input logic [31:0] rdy, input logic clr);
        bit acc;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        lane_en   = en;
        out_ready = rdy;
        err_clr   = clr;
        #1;
        compare_all();
        acc = v && model_ready();
        @(posedge clk);
        for (int i = 0; i < 32; i++)
            if (m_v[i] && rdy[i]) m_v[i] = 1'b0;
        if (acc && en[s]) begin
            m_v[s] = 1'b1;
            m_d[s] = d;
        end
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
            m_sel = '0;
        end else if (acc && !en[s]) begin
            if (m_cnt < 255) m_cnt++;
            m_err = 1'b1;
            m_sel = s;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] en, input logic [31:0] rdy);
        cycle(1'b0, 5'd0, 2'd0, en, rdy, 1'b0);
    endtask

    task automatic rand_cycles(input int n, input int en_zero_pct);
        logic [31:0] en;
        for (int k = 0; k < n; k++) begin
            en = '1;
            for (int i = 0; i < 32; i++)
                if ($urandom_range(99) < en_zero_pct) en[i] = 1'b0;
            cycle($urandom_range(3) != 0, 5'($urandom_range(31)), 2'($urandom),
                  en, $urandom, $urandom_range(49) == 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        lane_en   = '1;
        out_ready = '0;
        err_clr   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;

        // reset values
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        chk("rst err", err, 0);
        chk("rst err_sel", err_sel, 0);
        @(negedge clk);

        // single send to lane 12
        cycle(1'b1, 5'd12, 2'b10, '1, '0, 1'b0);
        #1;
        chk("lane12 valid", out_valid, 32'h0000_1000);
        chk("lane12 data", out_data[25:24], 2'b10);
        cycle(1'b0, 5'd0, 2'd0, '1, 32'h0000_1000, 1'b0);

        // lane 5 back-pressure, then accept in the pop cycle
        cycle(1'b1, 5'd5, 2'b01, '1, '0, 1'b0);
        cycle(1'b1, 5'd5, 2'b11, '1, '0, 1'b0);
        chk("lane5 stall", in_ready, 0);
        cycle(1'b1, 5'd5, 2'b11, '1, 32'h0000_0020, 1'b0);
        #1;
        chk("lane5 refill valid", out_valid[5], 1);
        chk("lane5 refill data", out_data[11:10], 2'b11);
        idle('1, '1);

        // back-to-back to every lane
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 5'(i), 2'(i + 1), '1, '1, 1'b0);
        idle('1, '0);
        idle('1, '1);

        // 300 drops to disabled lane 12
        for (int k = 0; k < 300; k++)
            cycle(1'b1, 5'd12, 2'(k), 32'hFFFF_EFFF, '0, 1'b0);
        #1;
        chk("sat drop_cnt", drop_cnt, 8'd255);
        chk("sat err", err, 1);
        chk("sat err_sel", err_sel, 5'd12);
        chk("sat lane12", out_valid[12], 0);
        cycle(1'b1, 5'd12, 2'b00, 32'hFFFF_EFFF, '0, 1'b1);
        #1;
        chk("clr drop_cnt", drop_cnt, 0);
        chk("clr err", err, 0);
        chk("clr err_sel", err_sel, 0);

        // lane 3 full then disabled: drains, later send dropped
        cycle(1'b1, 5'd3, 2'b01, '1, '0, 1'b0);
        idle(32'hFFFF_FFF7, '0);
        #1;
        chk("lane3 held", out_valid[3], 1);
        idle(32'hFFFF_FFF7, 32'h8);
        #1;
        chk("lane3 drained", out_valid[3], 0);
        cycle(1'b1, 5'd3, 2'b10, 32'hFFFF_FFF7, '0, 1'b0);
        #1;
        chk("lane3 drop", drop_cnt, 1);
        chk("lane3 err_sel", err_sel, 5'd3);

        // randomized traffic
        rand_cycles(1500, 10);
        rand_cycles(500, 60);

        // async reset with lanes full
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 5'(i * 3), 2'(i), '1, '0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async drop_cnt", drop_cnt, 0);
        chk("async err", err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rand_cycles(800, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
